// File: rtl/srt4_pkg.sv
// Shared types and constants for the srt4 host sequencer.
package srt4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_SEND_A,
    S_SEND_B,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DIV0    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int DEF_TIMEOUT        = 64;
  localparam int DEF_RECOVER_CYCLES = 2;

endpackage

// File: rtl/srt4_host_cycle_timer.sv
// Up-counter with clear and enable; expired is high once the count reaches
// LIMIT-1, i.e. on the LIMIT-th enabled cycle after a clear. Saturates there.
module cycle_timer #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // count enabled cycles since the last clear, holding at the terminal value
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/srt4_host.sv
// Host-side sequencer for the srt4 byte-serial divider.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | ready for a request; div0 requests bypass the divider
//   BEGIN     | div_begin pulse, inbus idle
//   SEND_A    | dividend on div_inbus
//   SEND_B    | divisor on div_inbus, wait timer and history cleared
//   WAIT      | track div_outbus until div_end or timeout
//   RECOVER   | hold div_rst_b low after a timeout
//   RESP      | present response until rsp_ready
module srt4_host
  import srt4_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_quotient,
  output logic [DATA_W-1:0] rsp_remainder,
  output logic [1:0]        rsp_status,
  output logic              div_begin,
  output logic [DATA_W-1:0] div_inbus,
  input  logic [DATA_W-1:0] div_outbus,
  input  logic              div_end,
  output logic              div_rst_b
);

  state_t            state, state_next;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] history;
  logic              wait_exp, rec_exp;

  cycle_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == S_SEND_B),
    .en      (state == S_WAIT),
    .expired (wait_exp)
  );

  cycle_timer #(.LIMIT(RECOVER_CYCLES)) u_rec_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != S_RECOVER),
    .en      (state == S_RECOVER),
    .expired (rec_exp)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // next-state decode; div_end beats a simultaneous timeout
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (req_valid) state_next = (req_divisor == '0) ? S_RESP : S_BEGIN;
      S_BEGIN:   state_next = S_SEND_A;
      S_SEND_A:  state_next = S_SEND_B;
      S_SEND_B:  state_next = S_WAIT;
      S_WAIT: begin
        if (div_end)       state_next = S_RESP;
        else if (wait_exp) state_next = S_RECOVER;
      end
      S_RECOVER: if (rec_exp) state_next = S_RESP;
      S_RESP:    if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // divider-side outputs are registered from the next state so they line up
  // with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      div_begin <= 1'b0;
      div_inbus <= '0;
      div_rst_b <= 1'b0;
    end else begin
      div_begin <= (state_next == S_BEGIN);
      div_rst_b <= (state_next != S_RECOVER);
      case (state_next)
        S_SEND_A: div_inbus <= op_a;
        S_SEND_B: div_inbus <= op_b;
        default:  div_inbus <= '0;
      endcase
    end
  end

  // operand latch and quotient history (outbus one cycle before div_end)
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      history <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        op_a <= req_dividend;
        op_b <= req_divisor;
      end
      if (state == S_SEND_B)    history <= '0;
      else if (state == S_WAIT) history <= div_outbus;
    end
  end

  // response registers; untouched while in RESP so they stay stable
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_status    <= ST_OK;
    end else if (state == S_IDLE && req_valid && req_divisor == '0) begin
      rsp_quotient  <= '1;
      rsp_remainder <= req_dividend;
      rsp_status    <= ST_DIV0;
    end else if (state == S_WAIT && div_end) begin
      rsp_quotient  <= history;
      rsp_remainder <= div_outbus;
      rsp_status    <= ST_OK;
    end else if (state == S_WAIT && wait_exp) begin
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_status    <= ST_TIMEOUT;
    end
  end

endmodule
